// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the CPU-to-memory bus controller.
package bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_MMIO, REG_NONE} region_t;
    localparam int WCNT_W = 4;
    localparam logic [3:0] MMIO_CYCLE   = 4'h0;
    localparam logic [3:0] MMIO_SCRATCH = 4'h4;
    localparam logic [3:0] MMIO_HALT    = 4'h8;
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: maps a byte address to its region, in-region offset and alignment flag.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0000_0000,
    parameter int                ROM_AW    = 12,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h1000_0000,
    parameter int                RAM_AW    = 12,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_t           region_o,
    output logic [ADDR_W-1:0] offset_o,
    output logic              misaligned_o
);
    localparam logic [ADDR_W-1:0] ROM_MASK  = {ADDR_W{1'b1}} >> (ADDR_W - ROM_AW);
    localparam logic [ADDR_W-1:0] RAM_MASK  = {ADDR_W{1'b1}} >> (ADDR_W - RAM_AW);
    localparam logic [ADDR_W-1:0] MMIO_MASK = {{(ADDR_W-4){1'b0}}, 4'hF};
    logic rom_hit, ram_hit, mmio_hit;
    always_comb begin
        rom_hit      = (addr_i & ~ROM_MASK) == (ROM_BASE & ~ROM_MASK);
        ram_hit      = (addr_i & ~RAM_MASK) == (RAM_BASE & ~RAM_MASK);
        mmio_hit     = (addr_i & ~MMIO_MASK) == (MMIO_BASE & ~MMIO_MASK);
        region_o     = rom_hit ? REG_ROM : ram_hit ? REG_RAM : mmio_hit ? REG_MMIO : REG_NONE;
        offset_o     = addr_i & (rom_hit ? ROM_MASK : ram_hit ? RAM_MASK : MMIO_MASK);
        misaligned_o = |addr_i[1:0];
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: decodes CPU accesses to ROM/RAM/MMIO, inserts wait states and
// returns a registered one-cycle response; hosts the cycle, scratch and halt registers.
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0000_0000,
    parameter int                ROM_AW    = 12,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h1000_0000,
    parameter int                RAM_AW    = 12,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hF000_0000,
    parameter int                ROM_WAIT  = 0,
    parameter int                RAM_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              halt_req
);
    bus_state_t        state_q, state_d;
    region_t           region, region_q;
    logic [ADDR_W-1:0] offset, off_q;
    logic [DATA_W-1:0] wdata_q, cycle_q, scratch_q, rdata_d, rsp_rdata_q;
    logic [WCNT_W-1:0] cnt_q, cnt_d, wait_d;
    logic              misaligned, we_q, err_q, err_d, halt_q, rsp_valid_q, rsp_err_q;
    logic              accept, done, mmio_wr;

    bus_addr_decode #(
        .ADDR_W(ADDR_W), .ROM_BASE(ROM_BASE), .ROM_AW(ROM_AW),
        .RAM_BASE(RAM_BASE), .RAM_AW(RAM_AW), .MMIO_BASE(MMIO_BASE)
    ) u_dec (
        .addr_i(req_addr), .region_o(region), .offset_o(offset), .misaligned_o(misaligned)
    );

    always_comb begin
        accept  = req_valid && state_q == IDLE;
        done    = state_q == WAIT && cnt_q == '0;
        err_d   = misaligned || region == REG_NONE || (region == REG_ROM && req_we) ||
                  (region == REG_MMIO && !(offset[3:0] == MMIO_SCRATCH || offset[3:0] == MMIO_HALT ||
                                           (offset[3:0] == MMIO_CYCLE && !req_we)));
        wait_d  = err_d ? '0 : region == REG_ROM ? WCNT_W'(ROM_WAIT) :
                  region == REG_RAM ? WCNT_W'(RAM_WAIT) : '0;
        state_d = accept ? WAIT : done ? RESP : state_q == RESP ? IDLE : state_q;
        cnt_d   = accept ? wait_d : (state_q == WAIT && !done) ? cnt_q - WCNT_W'(1) : cnt_q;
        rdata_d = (err_q || we_q) ? '0 :
                  region_q == REG_ROM ? rom_rdata :
                  region_q == REG_RAM ? ram_rdata :
                  off_q[3:0] == MMIO_CYCLE ? cycle_q :
                  off_q[3:0] == MMIO_SCRATCH ? scratch_q : DATA_W'(halt_q);
        mmio_wr = done && we_q && !err_q && region_q == REG_MMIO;
    end

    // ram_wr is gated by reset so an abort never writes on the reset edge
    assign req_ready = state_q == IDLE;
    assign ram_rd    = state_q == WAIT && region_q == REG_RAM && !we_q && !err_q;
    assign ram_wr    = done && region_q == REG_RAM && we_q && !err_q && reset;
    assign rom_addr  = off_q;
    assign ram_addr  = off_q;
    assign ram_wdata = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign halt_req  = halt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            region_q    <= REG_NONE;
            off_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cycle_q     <= '0;
            scratch_q   <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycle_q     <= cycle_q + DATA_W'(1);
            rsp_valid_q <= state_q == RESP;
            if (accept) begin
                region_q <= region;
                off_q    <= offset;
                we_q     <= req_we;
                err_q    <= err_d;
                wdata_q  <= req_wdata;
            end
            if (done) begin
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= err_q;
            end
            if (mmio_wr && off_q[3:0] == MMIO_SCRATCH) scratch_q <= wdata_q;
            if (mmio_wr && off_q[3:0] == MMIO_HALT && wdata_q[0]) halt_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: scoreboard bench for mem_bus_ctrl; a second instance with RAM_WAIT=3 covers mid-access reset.
module tb_mem_bus_ctrl;
    logic clk = 0, reset = 0, req_valid = 0, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, rsp_valid, rsp_err, ram_rd, ram_wr, halt_req;
    logic [31:0] rsp_rdata, rom_addr, rom_rdata, ram_addr, ram_wdata, ram_rdata;
    logic w3_req_ready, w3_rsp_valid, w3_rsp_err, w3_ram_rd, w3_ram_wr, w3_halt_req;
    logic [31:0] w3_rsp_rdata, w3_rom_addr, w3_ram_addr, w3_ram_wdata;
    logic [31:0] mem [0:15];
    typedef struct { logic [31:0] rdata; logic err; int lat; longint acc; } exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0, wr_cnt = 0, w3_wr_cnt = 0, w3_rsp_cnt = 0, wr_save = 0;
    logic rd_seen = 0;
    logic [31:0] wr_addr = 0, wr_data = 0;
    longint t_rel = 0, t_acc = 0, t_prev = 0;

    always #5 clk = ~clk;

    assign rom_rdata = (rom_addr == 32'h4) ? 32'h1234_5678 : 32'hCAFE_0000;
    assign ram_rdata = mem[ram_addr[5:2]];
    always @(posedge clk) if (ram_wr) mem[ram_addr[5:2]] <= ram_wdata;

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .ram_addr(ram_addr),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .halt_req(halt_req)
    );

    mem_bus_ctrl #(.RAM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(w3_req_ready), .rsp_valid(w3_rsp_valid),
        .rsp_rdata(w3_rsp_rdata), .rsp_err(w3_rsp_err), .rom_addr(w3_rom_addr),
        .rom_rdata(rom_rdata), .ram_addr(w3_ram_addr), .ram_rd(w3_ram_rd), .ram_wr(w3_ram_wr),
        .ram_wdata(w3_ram_wdata), .ram_rdata(ram_rdata), .halt_req(w3_halt_req)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // cyc=1: expected read value is the cycle counter at the sampling edge (accept + 1)
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat,
                         input bit push, input bit cyc);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        t_prev = t_acc;
        t_acc = $time;
        if (push) q.push_back('{cyc ? 32'(($time + 10 - t_rel) / 10) : exp_rd, exp_err, lat, $time});
        #1;
        req_valid = 0; req_we = 0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'hBAD0_BAD0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        t_rel = $time;
    endtask

    always @(negedge clk) begin
        if (ram_wr) begin
            wr_cnt++;
            wr_addr = ram_addr;
            wr_data = ram_wdata;
        end
        if (ram_rd) rd_seen = 1;
        if (w3_ram_wr) w3_wr_cnt++;
        if (w3_rsp_valid) w3_rsp_cnt++;
        if (reset && rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
            else begin
                e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_latency", 64'(($time - 5 - e.acc) / 10), 64'(e.lat));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h1000_0010; req_wdata = 32'h5555_5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_halt", halt_req, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_no_wr", wr_cnt, 0);
        reset = 1; req_valid = 0;
        @(posedge clk);
        t_rel = $time;

        issue(1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 0, 3, 1, 0);
        issue(0, 32'h1000_0010, 0, 32'hDEAD_BEEF, 0, 3, 1, 0);
        drain();
        chk("ram_wr_pulses", wr_cnt, 1);
        chk("ram_wr_addr", wr_addr, 32'h10);
        chk("ram_wr_data", wr_data, 32'hDEAD_BEEF);

        rd_seen = 0;
        issue(0, 32'h0000_0004, 0, 32'h1234_5678, 0, 2, 1, 0);
        issue(1, 32'h0000_0004, 32'h7777_7777, 0, 1, 2, 1, 0);
        issue(0, 32'h1000_0002, 0, 0, 1, 2, 1, 0);
        issue(0, 32'h8000_0000, 0, 0, 1, 2, 1, 0);
        drain();
        chk("err_no_ram_rd", rd_seen, 0);
        chk("err_no_ram_wr", wr_cnt, 1);

        issue(1, 32'hF000_0004, 32'hA5, 0, 0, 2, 1, 0);
        issue(0, 32'hF000_0004, 0, 32'hA5, 0, 2, 1, 0);
        issue(0, 32'hF000_0000, 0, 0, 0, 2, 1, 1);
        issue(0, 32'hF000_0000, 0, 0, 0, 2, 1, 1);
        chk("cycle_spacing", 64'((t_acc - t_prev) / 10), 3);
        issue(1, 32'hF000_0000, 32'h1, 0, 1, 2, 1, 0);
        issue(0, 32'hF000_000C, 0, 0, 1, 2, 1, 0);
        issue(1, 32'hF000_0008, 32'h1, 0, 0, 2, 1, 0);
        drain();
        chk("halt_set", halt_req, 1);
        issue(1, 32'hF000_0008, 32'h0, 0, 0, 2, 1, 0);
        issue(0, 32'hF000_0008, 0, 32'h1, 0, 2, 1, 0);
        drain();
        chk("halt_sticky", halt_req, 1);
        chk("mmio_no_ram_wr", wr_cnt, 1);

        do_reset();
        @(negedge clk);
        chk("halt_cleared", halt_req, 0);
        chk("post_rst_ready", req_ready, 1);

        w3_wr_cnt = 0; w3_rsp_cnt = 0; wr_save = wr_cnt;
        issue(1, 32'h1000_0020, 32'h1111_1111, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        repeat (8) @(negedge clk);
        chk("abort_no_ram_wr", w3_wr_cnt, 0);
        chk("abort_no_rsp", w3_rsp_cnt, 0);
        chk("abort_idle", w3_req_ready, 1);
        chk("abort_main_no_wr", wr_cnt, wr_save);
        chk("abort_mem", mem[8], 0);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
